uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
Bit-level UART receiver directly upstream of the hex-text parser. It oversamples the raw RX pin at 4x baud and deframes 8N1 characters. Each good character is delivered as a one-cycle byte strobe that feeds the parser's uart_rx_byte_en/uart_rx_byte inputs. Framing errors are flagged separately and never strobed as data.

Parameters:
CLK_DIV, 108, clocks per oversample tick; baud = clk freq/(4*CLK_DIV); legal range ≥2 (e.g. 125MHz, 271 -> 115200)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
i_uart_rx  input  1  raw asynchronous RX pin, idle high
uart_rx_byte_en  output  1  one-cycle strobe, byte valid
uart_rx_byte  output  8  received byte, LSB received first; held until next strobe
frame_err  output  1  one-cycle strobe, stop bit sampled low

Behaviour:
- Reset (async, rstn low): uart_rx_byte_en=0, uart_rx_byte=0, frame_err=0, FSM=IDLE, counters=0, synchronizer flops=1.
- Input path: 2-flop synchronizer on i_uart_rx, then one history flop. Falling edge = history 1 and synced 0.
- Tick counter: runs 0..CLK_DIV-1. tick=1 on the cycle count==CLK_DIV-1.
- Phase counter: 2 bits, advanced on tick; each bit spans 4 ticks. Bit counter: 3 bits.
- Tick, phase and bit counters all clear to 0 on falling-edge detect in IDLE.
- Decision point: the tick at which phase==3. Bit value per Optional Feature.
- IDLE: on falling edge -> START.
- START: at decision point, bit 0 -> DATA with bit counter=0; bit 1 -> IDLE (glitch reject, no output).
- DATA: at each decision point, shift the bit into the shift register MSB (right shift, so LSB-first ends aligned). At bit counter 7 -> STOP, else increment the bit counter.
- STOP: at decision point:
  - bit 1: next cycle uart_rx_byte_en=1 and uart_rx_byte=shift register; FSM -> IDLE.
  - bit 0: next cycle frame_err=1 and uart_rx_byte unchanged; FSM -> BREAK.
- BREAK: wait for synced rx=1 -> IDLE. A line held low (break) yields exactly one frame_err, no repeats.
- Back-to-back characters: returning to IDLE at the stop-bit decision point leaves about 1 tick of stop bit. The next start edge is accepted immediately, with no extra idle time required.
- Latency: start-edge detect to strobe = 39*CLK_DIV + 1 cycles, from (9 full bits + 3 ticks)*CLK_DIV + output register. Add 3 cycles of synchronizer/edge pipeline from the pin.
- uart_rx_byte_en and frame_err never assert in the same cycle; each is high for exactly 1 cycle.
- rstn asserted mid-character: the partial character is discarded. After release, the FSM waits in IDLE for a fresh falling edge. A line low at release is not treated as a start, because the history flop resets to 1 and the synced value must first read 1.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: synced rx is sampled on the ticks with phase 1, 2 and 3. The bit value is the 2-of-3 majority, used at the decision point for START, DATA and STOP.
- Undefined: the bit value is the single sample at the phase-2 tick.
- Decision timing and latency are identical in both builds.

Decomposition:
- Shared package uart_pkg: UART_DATA_BITS=8, UART_OVERSAMPLE=4, default CLK_DIV=108. The parser and future uart_tx use the same values.
- FSM state encodings (IDLE, START, DATA, STOP, BREAK) are local to this block.
- One sub-module: uart_baud_tick (CLK_DIV counter with synchronous clear input and tick output), reusable by uart_tx.

Test Plan:
All scenarios use CLK_DIV=4, so 1 bit = 16 clk.
1. Line idle high, send 0x41 8N1 -> one uart_rx_byte_en pulse with uart_rx_byte=0x41 at 39*4+1 clk after the edge (+3 pipeline); frame_err stays 0.
2. Send 0x30,0x0A back-to-back with a single stop bit -> two strobes, bytes 0x30 then 0x0A, 160 clk apart.
3. 8-clk low glitch, then high -> no strobe, no frame_err, FSM back in IDLE.
4. Send 0x55 with stop bit forced 0, then hold the line low for 64 bit times -> exactly one frame_err, no strobe; after the line returns high, 0x37 is received correctly.
5. Toggle rstn low during bit 4 of 0xA5, release with the line high, then send 0x5A -> no strobe for 0xA5; strobe with 0x5A; all outputs 0 during reset.
6. With UART_RX_MAJORITY_EN, flip a single phase-2 sample of each data bit of 0x3C -> received as 0x3C. Without the macro, the same stimulus yields 0xC3.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose: UART constants shared by the receive deserializer, the hex-text parser and uart_tx.
// Latency: none (constants and a pure combinational helper).
// Backpressure: not applicable.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 4;
  localparam int UART_CLK_DIV    = 108;
  localparam int UART_PHASE_W    = $clog2(UART_OVERSAMPLE);

  // 2-of-3 vote used when filtering noisy line samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Purpose: oversample tick generator, one-cycle tick every CLK_DIV clocks, restartable by clr.
// Latency: tick is high while the count sits at CLK_DIV-1; clr restarts the count from 0 next cycle.
// Backpressure: none, free-running.
module uart_baud_tick #(
  parameter int CLK_DIV = 108
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(CLK_DIV - 1));

  // Count 0..CLK_DIV-1, wrapping on tick; clr realigns to the caller's timing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// Purpose: 4x-oversampled 8N1 UART receiver; good bytes strobed on uart_rx_byte_en, bad stop bits on frame_err.
// Latency: 39*CLK_DIV+1 cycles from start-edge detect to strobe, plus the synchronizer/edge pipeline.
// Backpressure: none; the consumer must take each one-cycle strobe. Build option: UART_RX_MAJORITY_EN.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_uart_rx,
  output logic                      uart_rx_byte_en,
  output logic [UART_DATA_BITS-1:0] uart_rx_byte,
  output logic                      frame_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  localparam logic [UART_PHASE_W-1:0] PH_EARLY  = UART_PHASE_W'(1);
  localparam logic [UART_PHASE_W-1:0] PH_MID    = UART_PHASE_W'(2);
  localparam logic [UART_PHASE_W-1:0] PH_DECIDE = UART_PHASE_W'(UART_OVERSAMPLE - 1);
  localparam logic [2:0]              LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic                      rx_meta, rx_sync, rx_hist;
  logic                      fall, start_clr, tick, decide, bit_val;
  logic [2:0]                state;
  logic [UART_PHASE_W-1:0]   phase, phase_nxt;
  logic [2:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shreg;

  // Two-flop synchronizer plus history flop; all idle-high so a low line at release is not a start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_hist <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_sync <= rx_meta;
      rx_hist <= rx_sync;
    end
  end

  assign fall      = rx_hist & ~rx_sync;
  assign start_clr = (state == ST_IDLE) && fall;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (start_clr),
    .tick (tick)
  );

  // The phase a tick moves into names that tick; the decision lands on the tick reaching the last phase,
  // which leaves roughly one tick of stop bit for back-to-back characters.
  assign phase_nxt = phase + 1'b1;
  assign decide    = tick && (phase_nxt == PH_DECIDE);

  // Phase within the current bit, realigned to the start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase <= '0;
    end else if (start_clr) begin
      phase <= '0;
    end else if (tick) begin
      phase <= phase_nxt;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] smp;

  // Capture the first two of three votes; the third is the live sample at the decision tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      smp <= 2'b11;
    end else if (tick) begin
      if (phase_nxt == PH_EARLY) smp[0] <= rx_sync;
      if (phase_nxt == PH_MID)   smp[1] <= rx_sync;
    end
  end

  assign bit_val = maj3(smp[0], smp[1], rx_sync);
`else
  logic smp_mid;

  // Single mid-bit sample, consumed one tick later at the decision point.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      smp_mid <= 1'b1;
    end else if (tick && (phase_nxt == PH_MID)) begin
      smp_mid <= rx_sync;
    end
  end

  assign bit_val = smp_mid;
`endif

  // Frame FSM, LSB-first shift register and registered one-cycle output strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= ST_IDLE;
      bit_cnt         <= '0;
      shreg           <= '0;
      uart_rx_byte_en <= 1'b0;
      uart_rx_byte    <= '0;
      frame_err       <= 1'b0;
    end else begin
      uart_rx_byte_en <= 1'b0;
      frame_err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state   <= ST_START;
            bit_cnt <= '0;
          end
        end
        ST_START: begin
          if (decide) begin
            if (!bit_val) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (decide) begin
            shreg <= {bit_val, shreg[UART_DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (decide) begin
            if (bit_val) begin
              uart_rx_byte_en <= 1'b1;
              uart_rx_byte    <= shreg;
              state           <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Purpose: self-checking bench for uart_rx_deserializer at CLK_DIV=4 (16 clocks per bit).
// Latency: expected strobes are checked against a cycle window derived from the frame start.
// Backpressure: not applicable; the monitor consumes every strobe.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int DIV     = 4;
  localparam int BIT_CLK = 4 * DIV;
  localparam int FRM_CLK = 10 * BIT_CLK;
  // From the first clock edge that sees the pin low: two synchronizer edges, the FSM edge, then 39 ticks.
  localparam int LAT     = 39 * DIV + 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_uart_rx = 1'b1;
  logic       uart_rx_byte_en;
  logic [7:0] uart_rx_byte;
  logic       frame_err;

  always #5 clk = ~clk;

  uart_rx_deserializer #(.CLK_DIV(DIV)) u_dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_uart_rx       (i_uart_rx),
    .uart_rx_byte_en (uart_rx_byte_en),
    .uart_rx_byte    (uart_rx_byte),
    .frame_err       (frame_err)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] dat;
    int         t_min;
    int         t_max;
  } exp_t;

  typedef struct {
    logic [7:0] dat;
    int         gap_bits;
  } vec_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  exp_t       exp_q[$];
  int         strobe_q[$];
  logic [7:0] last_good = 8'h00;
  exp_t       mon_e;
  logic       prev_pulse = 1'b0;
  vec_t       tbl[7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard: every strobe pops one expectation pushed when its frame was driven.
  always @(posedge clk) begin
    #1;
    if (rstn && (uart_rx_byte_en || frame_err)) begin
      check("strobe_exclusive", int'(uart_rx_byte_en & frame_err), 0);
      check("pulse_width", int'(prev_pulse), 0);
      if (uart_rx_byte_en) strobe_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", int'({uart_rx_byte_en, frame_err}), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind", int'(frame_err), int'(mon_e.is_err));
        check("strobe_byte", int'(uart_rx_byte), int'(mon_e.dat));
        check_range("strobe_latency", cyc, mon_e.t_min, mon_e.t_max);
      end
    end
    prev_pulse = uart_rx_byte_en | frame_err;
  end

  // Drive one 8N1 frame (or its first ncyc clocks). exp_kind: 0 none, 1 byte, 2 framing error.
  task automatic drive_frame(input logic [7:0] b, input logic stop, input bit flip_mid,
                             input int ncyc, input int exp_kind, input logic [7:0] exp_dat);
    exp_t e;
    for (int j = 0; j < ncyc; j++) begin
      int   idx;
      logic v;
      idx = j / BIT_CLK;
      if (idx == 0)      v = 1'b0;
      else if (idx <= 8) v = b[idx-1];
      else               v = stop;
      if (flip_mid && idx >= 1 && idx <= 8 && (j % BIT_CLK) == BIT_CLK / 2) v = ~v;
      @(negedge clk);
      if (j == 0 && exp_kind != 0) begin
        e.is_err = (exp_kind == 2);
        e.dat    = exp_dat;
        e.t_min  = cyc + LAT;
        e.t_max  = cyc + LAT + 1;
        exp_q.push_back(e);
        if (exp_kind == 1) last_good = exp_dat;
      end
      i_uart_rx = v;
    end
  endtask

  task automatic line_hold(input logic v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_uart_rx = v;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge clk);
  endtask

  initial begin
    tbl[0] = '{8'h41, 1};
    tbl[1] = '{8'h30, 0};
    tbl[2] = '{8'h0A, 1};
    tbl[3] = '{8'h00, 1};
    tbl[4] = '{8'hFF, 1};
    tbl[5] = '{8'h80, 0};
    tbl[6] = '{8'h01, 2};

    // Reset state
    rstn = 1'b0;
    i_uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_byte_en", int'(uart_rx_byte_en), 0);
    check("reset_byte", int'(uart_rx_byte), 0);
    check("reset_frame_err", int'(frame_err), 0);
    @(negedge clk);
    rstn = 1'b1;
    line_hold(1'b1, 20);

    // Table of good characters, including a back-to-back pair with a single stop bit
    strobe_q.delete();
    for (int i = 0; i < 7; i++) begin
      drive_frame(tbl[i].dat, 1'b1, 1'b0, FRM_CLK, 1, tbl[i].dat);
      line_hold(1'b1, tbl[i].gap_bits * BIT_CLK);
    end
    drain();
    check("b2b_spacing", (strobe_q.size() > 2) ? strobe_q[2] - strobe_q[1] : -1, FRM_CLK);
    check("b2b_tail_spacing", (strobe_q.size() > 6) ? strobe_q[6] - strobe_q[5] : -1, FRM_CLK);

    // 8-clock low glitch is rejected, then the receiver still accepts a frame
    line_hold(1'b0, 8);
    line_hold(1'b1, 4 * BIT_CLK);
    check("glitch_pending", exp_q.size(), 0);
    drive_frame(8'h6B, 1'b1, 1'b0, FRM_CLK, 1, 8'h6B);
    line_hold(1'b1, BIT_CLK);

    // Bad stop bit followed by a long break: one frame_err, byte held, then recovery
    drive_frame(8'h55, 1'b0, 1'b0, FRM_CLK, 2, last_good);
    line_hold(1'b0, 64 * BIT_CLK);
    line_hold(1'b1, BIT_CLK);
    drive_frame(8'h37, 1'b1, 1'b0, FRM_CLK, 1, 8'h37);
    line_hold(1'b1, 2 * BIT_CLK);
    drain();

    // Reset during data bit 4 discards the partial character
    drive_frame(8'hA5, 1'b1, 1'b0, 5 * BIT_CLK + 8, 0, 8'h00);
    @(negedge clk);
    rstn = 1'b0;
    i_uart_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midreset_byte_en", int'(uart_rx_byte_en), 0);
    check("midreset_byte", int'(uart_rx_byte), 0);
    check("midreset_frame_err", int'(frame_err), 0);
    last_good = 8'h00;
    @(negedge clk);
    rstn = 1'b1;
    line_hold(1'b1, 3 * BIT_CLK);
    drive_frame(8'h5A, 1'b1, 1'b0, FRM_CLK, 1, 8'h5A);
    line_hold(1'b1, 2 * BIT_CLK);

    // One corrupted mid-bit sample per data bit: voting recovers it, single sampling inverts it
`ifdef UART_RX_MAJORITY_EN
    drive_frame(8'h3C, 1'b1, 1'b1, FRM_CLK, 1, 8'h3C);
`else
    drive_frame(8'h3C, 1'b1, 1'b1, FRM_CLK, 1, 8'hC3);
`endif
    line_hold(1'b1, 2 * BIT_CLK);

    drain();
    line_hold(1'b1, 2 * BIT_CLK);
    check("pending_expectations", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
